fix_conn_scheduler: RTL and testbench
=====================================

FIX_CONN_SCHEDULER -- requirements
Module: fix_conn_scheduler

Interface
REQ-001 SHALL have parameter TIMEOUT, 64, cycles to wait for connected_i after a connect request.
REQ-002 SHALL have parameter MAX_RETRY, 3, connect attempts per request before failure is declared.
REQ-003 SHALL have port clk  in  1  single clock; all flops rising-edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port conn_req_i  in  4  per-host connect request from app, level.
REQ-006 SHALL have port disc_req_i  in  4  per-host disconnect request from app, level.
REQ-007 SHALL have port connected_i  in  1  connect acknowledge pulse from TOE.
REQ-008 SHALL have port connected_host_addr_i  in  2  host index qualifying connected_i.
REQ-009 SHALL have port connect_req_o  out  1  one-cycle connect strobe to fifo.
REQ-010 SHALL have port connect_addr_o  out  2  host index for connect_req_o.
REQ-011 SHALL have port disconnect_o  out  1  one-cycle disconnect strobe to fifo.
REQ-012 SHALL have port disconnect_host_num_o  out  2  host index for disconnect_o.
REQ-013 SHALL have port conn_state_o  out  4  bitmap of connected hosts.
REQ-014 SHALL have port conn_fail_o  out  4  one-cycle per-host failure pulse.
REQ-015 SHALL have port busy_o  out  1  high whenever FSM is not IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, ARB, CONNECT, WAIT_ACK, DISCONNECT.
REQ-017 SHALL treat a host as pending-connect when conn_req_i[h]=1 and conn_state_o[h]=0; pending-disconnect when disc_req_i[h]=1 and conn_state_o[h]=1; other requests ignored.
REQ-018 SHALL move IDLE->ARB when any host is pending, else remain IDLE.
REQ-019 SHALL in ARB select one host round-robin starting at (last granted + 1) mod 4, pending-disconnect hosts taking priority over pending-connect hosts; ARB lasts exactly one cycle.
REQ-020 SHALL, if both requests are pending for the same connected host, service the disconnect.
REQ-021 SHALL in CONNECT assert connect_req_o=1 with connect_addr_o=granted host for exactly one cycle, clear the timeout counter, then enter WAIT_ACK.
REQ-022 SHALL in WAIT_ACK count cycles; connected_i=1 with connected_host_addr_i equal to granted host sets conn_state_o[host] next cycle and returns to IDLE.
REQ-023 SHALL ignore connected_i with non-matching address and connected_i outside WAIT_ACK.
REQ-024 SHALL treat a matching connected_i arriving in the cycle the counter reaches TIMEOUT-1 as success.
REQ-025 SHALL on timeout re-enter CONNECT if attempts < MAX_RETRY, else pulse conn_fail_o[host] one cycle and return to IDLE.
REQ-026 SHALL in DISCONNECT assert disconnect_o=1 with disconnect_host_num_o=granted host for one cycle, clear conn_state_o[host] next cycle, return to IDLE.
REQ-027 SHALL update the round-robin pointer only on leaving CONNECT/WAIT_ACK or DISCONNECT.
REQ-028 SHALL drive address outputs to 0 when their strobe is low.
REQ-029 SHALL size the timeout counter to $clog2(TIMEOUT)+1 bits, saturating, no wrap.

Reset
REQ-030 SHALL on rst=1, asynchronously and mid-operation, force state IDLE, all outputs 0, conn_state_o=0, retry count 0, pointer to host 0.
REQ-031 SHALL leave the first post-reset ARB to consider host 0 first.

Structure
REQ-032 SHALL place the FSM state enum, NUM_HOSTS=4 and HOST_W=2 in shared package fix_pkg.
REQ-033 SHALL implement the 4-way round-robin selector as sub-module fix_rr_arb (req[3:0], ptr[1:0] -> grant index, grant_valid).

Verification
REQ-034 SHALL cover: conn_req_i=0001, connected_i with addr 0 four cycles after connect_req_o -> conn_state_o=0001, busy_o low next cycle.
REQ-035 SHALL cover: conn_req_i=0100, no ack, TIMEOUT=8 MAX_RETRY=3 -> three connect_req_o pulses with addr 2 spaced 9 cycles, then conn_fail_o=0100 for one cycle.
REQ-036 SHALL cover: conn_req_i=1111 from reset with acks -> connect_addr_o order 0,1,2,3.
REQ-037 SHALL cover: host 1 connected, conn_req_i[1]=disc_req_i[1]=1 -> disconnect_o with host 1, conn_state_o[1]=0.
REQ-038 SHALL cover: connected_i with addr 3 during WAIT_ACK for host 0 -> ignored, conn_state_o unchanged.
REQ-039 SHALL cover: rst asserted in WAIT_ACK -> outputs and conn_state_o zero immediately, no further strobe.

Source files
------------

// File: rtl/fix_pkg.sv
// Shared definitions for the FIX connection scheduler: host count, host index
// width and the scheduler FSM state encoding.
package fix_pkg;

  localparam int NUM_HOSTS = 4;
  localparam int HOST_W    = 2;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    CONNECT,
    WAIT_ACK,
    DISCONNECT
  } fix_state_t;

  function automatic logic [NUM_HOSTS-1:0] host_onehot(input logic [HOST_W-1:0] h);
    return NUM_HOSTS'(1) << h;
  endfunction

endpackage

// File: rtl/fix_rr_arb.sv
// Four-way round-robin selector: returns the first requesting host found when
// scanning upward (with wrap) from ptr.
module fix_rr_arb
  import fix_pkg::*;
(
  input  logic [NUM_HOSTS-1:0] req,
  input  logic [HOST_W-1:0]    ptr,
  output logic [HOST_W-1:0]    grant,
  output logic                 grant_valid
);

  logic [HOST_W-1:0] idx;

  // Scan from farthest to nearest so the host closest to ptr is written last.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    idx         = '0;
    for (int i = NUM_HOSTS - 1; i >= 0; i--) begin
      idx = ptr + HOST_W'(i);
      if (req[idx]) begin
        grant       = idx;
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fix_conn_scheduler.sv
// Serialises per-host connect/disconnect requests towards the TOE, with
// round-robin fairness, acknowledge timeout and bounded connect retries.
module fix_conn_scheduler
  import fix_pkg::*;
#(
  parameter int TIMEOUT   = 64,
  parameter int MAX_RETRY = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_HOSTS-1:0] conn_req_i,
  input  logic [NUM_HOSTS-1:0] disc_req_i,
  input  logic                 connected_i,
  input  logic [HOST_W-1:0]    connected_host_addr_i,
  output logic                 connect_req_o,
  output logic [HOST_W-1:0]    connect_addr_o,
  output logic                 disconnect_o,
  output logic [HOST_W-1:0]    disconnect_host_num_o,
  output logic [NUM_HOSTS-1:0] conn_state_o,
  output logic [NUM_HOSTS-1:0] conn_fail_o,
  output logic                 busy_o
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  localparam int ATT_W = $clog2(MAX_RETRY + 1) + 1;

  fix_state_t           state, state_nxt;
  logic [HOST_W-1:0]    host_q;
  logic [HOST_W-1:0]    ptr_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [ATT_W-1:0]     att_q;

  logic [NUM_HOSTS-1:0] pend_conn, pend_disc, arb_req;
  logic [HOST_W-1:0]    arb_grant;
  logic                 arb_valid;
  logic                 ack_hit, timeout_hit, retry_ok, leave_job;

  assign pend_conn   = conn_req_i & ~conn_state_o;
  assign pend_disc   = disc_req_i & conn_state_o;
  // Disconnects win outright; a connected host can never also be pending-connect.
  assign arb_req     = (|pend_disc) ? pend_disc : pend_conn;
  assign ack_hit     = connected_i && (connected_host_addr_i == host_q);
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));
  assign retry_ok    = (att_q < ATT_W'(MAX_RETRY));
  assign leave_job   = ((state == WAIT_ACK) && (state_nxt == IDLE)) || (state == DISCONNECT);

  fix_rr_arb u_arb (
    .req         (arb_req),
    .ptr         (ptr_q),
    .grant       (arb_grant),
    .grant_valid (arb_valid)
  );

  always_comb begin
    state_nxt             = state;
    connect_req_o         = 1'b0;
    connect_addr_o        = '0;
    disconnect_o          = 1'b0;
    disconnect_host_num_o = '0;
    busy_o                = (state != IDLE);
    case (state)
      IDLE:       if (|(pend_conn | pend_disc)) state_nxt = ARB;
      ARB: begin
        if (!arb_valid)      state_nxt = IDLE;
        else if (|pend_disc) state_nxt = DISCONNECT;
        else                 state_nxt = CONNECT;
      end
      CONNECT: begin
        connect_req_o  = 1'b1;
        connect_addr_o = host_q;
        state_nxt      = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (ack_hit)          state_nxt = IDLE;
        else if (timeout_hit) state_nxt = retry_ok ? CONNECT : IDLE;
      end
      DISCONNECT: begin
        disconnect_o          = 1'b1;
        disconnect_host_num_o = host_q;
        state_nxt             = IDLE;
      end
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      host_q       <= '0;
      ptr_q        <= '0;
      cnt_q        <= '0;
      att_q        <= '0;
      conn_state_o <= '0;
      conn_fail_o  <= '0;
    end else begin
      state       <= state_nxt;
      conn_fail_o <= '0;
      if (state == ARB) begin
        att_q <= '0;
        if (arb_valid) host_q <= arb_grant;
      end
      if (state == CONNECT) begin
        cnt_q <= '0;
        att_q <= att_q + 1'b1;
      end else if ((state == WAIT_ACK) && (cnt_q != '1)) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if ((state == WAIT_ACK) && ack_hit)
        conn_state_o <= conn_state_o | host_onehot(host_q);
      if ((state == WAIT_ACK) && !ack_hit && timeout_hit && !retry_ok)
        conn_fail_o <= host_onehot(host_q);
      if (state == DISCONNECT)
        conn_state_o <= conn_state_o & ~host_onehot(host_q);
      if (leave_job) ptr_q <= host_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_fix_conn_scheduler.sv
// Self-checking bench for fix_conn_scheduler: cycle vectors, directed corner
// sequences, and randomized traffic against a transaction-age reference model.
module tb_fix_conn_scheduler;

  localparam int T = 8;
  localparam int R = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] conn_req = '0;
  logic [3:0] disc_req = '0;
  logic       connected = 1'b0;
  logic [1:0] conn_addr = '0;

  logic       connect_req_o;
  logic [1:0] connect_addr_o;
  logic       disconnect_o;
  logic [1:0] disconnect_host_num_o;
  logic [3:0] conn_state_o;
  logic [3:0] conn_fail_o;
  logic       busy_o;

  fix_conn_scheduler #(.TIMEOUT(T), .MAX_RETRY(R)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .conn_req_i            (conn_req),
    .disc_req_i            (disc_req),
    .connected_i           (connected),
    .connected_host_addr_i (conn_addr),
    .connect_req_o         (connect_req_o),
    .connect_addr_o        (connect_addr_o),
    .disconnect_o          (disconnect_o),
    .disconnect_host_num_o (disconnect_host_num_o),
    .conn_state_o          (conn_state_o),
    .conn_fail_o           (conn_fail_o),
    .busy_o                (busy_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  function automatic logic [15:0] outs();
    return {connect_req_o, connect_addr_o, disconnect_o, disconnect_host_num_o,
            conn_state_o, conn_fail_o, busy_o};
  endfunction

  // Reference model: a job is described only by its kind, host and age in
  // cycles since arbitration began; every output follows from the age.
  bit         m_active = 1'b0;
  bit         m_disc   = 1'b0;
  int         m_age    = 0;
  logic [1:0] m_host   = '0;
  logic [1:0] m_ptr    = '0;
  logic [3:0] m_conn   = '0;
  logic [3:0] m_fail   = '0;

  function automatic logic [1:0] rr_pick(input logic [3:0] set, input logic [1:0] ptr);
    for (int k = 0; k < 4; k++)
      if (set[(int'(ptr) + k) % 4]) return 2'((int'(ptr) + k) % 4);
    return 2'd0;
  endfunction

  always @(negedge clk) begin
    logic [15:0] exp_v;
    logic [3:0]  pc, pd, nf;
    logic        e_cr, e_dc;
    int          o, k;
    if (rst) begin
      m_active = 1'b0; m_disc = 1'b0; m_age = 0;
      m_host = '0; m_ptr = '0; m_conn = '0; m_fail = '0;
    end
    e_cr  = m_active && !m_disc && (m_age >= 1) && (((m_age - 1) % (T + 1)) == 0);
    e_dc  = m_active && m_disc && (m_age == 1);
    exp_v = {e_cr, e_cr ? m_host : 2'b00, e_dc, e_dc ? m_host : 2'b00,
             m_conn, m_fail, m_active};
    check($sformatf("model cyc %0d", cyc), outs(), exp_v);
    if (!rst) begin
      pc = conn_req & ~m_conn;
      pd = disc_req & m_conn;
      nf = '0;
      if (!m_active) begin
        if ((pc | pd) != 0) begin m_active = 1'b1; m_age = 0; end
      end else if (m_age == 0) begin
        if ((pc | pd) == 0) m_active = 1'b0;
        else begin
          m_disc = (pd != 0);
          m_host = rr_pick((pd != 0) ? pd : pc, m_ptr);
          m_age  = 1;
        end
      end else if (m_disc) begin
        m_conn[m_host] = 1'b0;
        m_ptr = m_host + 2'd1;
        m_active = 1'b0;
      end else begin
        o = (m_age - 1) % (T + 1);
        k = (m_age - 1) / (T + 1);
        if (o == 0) m_age++;
        else if (connected && conn_addr == m_host) begin
          m_conn[m_host] = 1'b1;
          m_ptr = m_host + 2'd1;
          m_active = 1'b0;
        end else if (o == T) begin
          if (k + 1 < R) m_age++;
          else begin
            nf[m_host] = 1'b1;
            m_ptr = m_host + 2'd1;
            m_active = 1'b0;
          end
        end else m_age++;
      end
      m_fail = nf;
    end
    cyc++;
  end

  typedef struct {
    logic [3:0] conn;
    logic [3:0] disc;
    logic       ack;
    logic [1:0] ack_addr;
    logic       cr;
    logic [1:0] ca;
    logic [3:0] cs;
    logic       busy;
  } vec_t;

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; conn_req = '0; disc_req = '0; connected = 1'b0; conn_addr = '0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    vec_t       tbl [9];
    int         pulses[$];
    int         fails[$];
    logic [1:0] order[$];
    logic [3:0] fail_val;
    int         ack_at;
    logic [1:0] ack_a;
    bit         found;
    int         strobes;

    tbl[0] = '{4'b0001, 4'b0000, 1'b0, 2'd0, 1'b0, 2'd0, 4'b0000, 1'b0};
    tbl[1] = '{4'b0001, 4'b0000, 1'b0, 2'd0, 1'b0, 2'd0, 4'b0000, 1'b1};
    tbl[2] = '{4'b0001, 4'b0000, 1'b0, 2'd0, 1'b1, 2'd0, 4'b0000, 1'b1};
    tbl[3] = '{4'b0001, 4'b0000, 1'b1, 2'd3, 1'b0, 2'd0, 4'b0000, 1'b1};
    tbl[4] = '{4'b0001, 4'b0000, 1'b0, 2'd0, 1'b0, 2'd0, 4'b0000, 1'b1};
    tbl[5] = '{4'b0001, 4'b0000, 1'b0, 2'd0, 1'b0, 2'd0, 4'b0000, 1'b1};
    tbl[6] = '{4'b0001, 4'b0000, 1'b1, 2'd0, 1'b0, 2'd0, 4'b0000, 1'b1};
    tbl[7] = '{4'b0001, 4'b0000, 1'b0, 2'd0, 1'b0, 2'd0, 4'b0001, 1'b0};
    tbl[8] = '{4'b0001, 4'b0000, 1'b0, 2'd0, 1'b0, 2'd0, 4'b0001, 1'b0};

    @(posedge clk); #1;
    check("reset outputs", outs(), 16'h0);
    rst = 1'b0;

    // Single connect, acked four cycles after the strobe; stray ack to host 3 ignored.
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      conn_req = tbl[i].conn; disc_req = tbl[i].disc;
      connected = tbl[i].ack; conn_addr = tbl[i].ack_addr;
      @(negedge clk);
      check($sformatf("vec %0d", i), {connect_req_o, connect_addr_o, conn_state_o, busy_o},
            {tbl[i].cr, tbl[i].ca, tbl[i].cs, tbl[i].busy});
    end

    // Unanswered connect to host 2: three attempts then a single failure pulse.
    do_reset();
    for (int c = 0; c < 33; c++) begin
      @(posedge clk); #1;
      if (c == 0)  conn_req = 4'b0100;
      if (c == 29) conn_req = 4'b0000;
      @(negedge clk);
      if (connect_req_o) begin
        pulses.push_back(c);
        check("retry addr", 32'(connect_addr_o), 32'd2);
      end
      if (conn_fail_o != 0) begin
        fails.push_back(c);
        fail_val = conn_fail_o;
      end
    end
    check("retry count", pulses.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < pulses.size()) check($sformatf("retry %0d cycle", i), pulses[i], 2 + 9 * i);
    check("fail pulse count", fails.size(), 1);
    if (fails.size() > 0) begin
      check("fail cycle", fails[0], 29);
      check("fail value", 32'(fail_val), 32'h4);
    end

    // All four hosts requesting from reset are granted in order 0,1,2,3.
    do_reset();
    ack_at = -1; ack_a = '0;
    for (int c = 0; c < 150; c++) begin
      @(posedge clk); #1;
      if (c == 0) conn_req = 4'b1111;
      connected = (c == ack_at);
      conn_addr = (c == ack_at) ? ack_a : 2'd0;
      @(negedge clk);
      if (connect_req_o) begin
        order.push_back(connect_addr_o);
        ack_at = c + 3;
        ack_a  = connect_addr_o;
      end
      if (order.size() == 4 && conn_state_o == 4'hF) break;
    end
    connected = 1'b0;
    check("rr grant count", order.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < order.size()) check($sformatf("rr grant %0d", i), 32'(order[i]), i);
    check("all connected", 32'(conn_state_o), 32'hF);

    // Connected host 1 with both requests high gets disconnected.
    @(posedge clk); #1;
    disc_req = 4'b0010;
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (disconnect_o) begin
        found = 1'b1;
        check("disc host", 32'(disconnect_host_num_o), 32'd1);
        break;
      end
    end
    check("disc seen", 32'(found), 32'd1);
    @(posedge clk); #1;
    disc_req = '0; conn_req = '0;
    @(negedge clk);
    check("disc state", 32'(conn_state_o), 32'hD);

    // Asynchronous reset while waiting for the host 1 acknowledge.
    do_reset();
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (c == 0) conn_req = 4'b0001;
      if (c == 7) conn_req = 4'b0011;
      connected = (c == 6);
      conn_addr = 2'd0;
      @(negedge clk);
    end
    check("pre-reset busy/state", {busy_o, conn_state_o}, 5'b10001);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("async reset outputs", outs(), 16'h0);
    @(posedge clk); #1;
    rst = 1'b0; conn_req = '0;
    strobes = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (connect_req_o || disconnect_o) strobes++;
    end
    check("no strobe after reset", strobes, 0);

    // Randomized traffic, checked every cycle by the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if ($urandom % 8 == 0)  conn_req = 4'($urandom);
      if ($urandom % 10 == 0) disc_req = 4'($urandom);
      connected = ($urandom % 5 == 0);
      conn_addr = ($urandom % 4 == 0) ? 2'($urandom) : m_host;
    end
    connected = 1'b0;
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
